// File: rtl/sync_fifo_pkg.sv
// Shared defaults and parameter-legality check for the synchronous FIFO.
package sync_fifo_pkg;

  localparam int unsigned DefWidth = 16;
  localparam int unsigned DefDepth = 8;

  // Depth must be a power of two so the pointers can wrap naturally.
  function automatic bit fifo_params_ok(input int unsigned width, input int unsigned depth,
                                        input int unsigned af, input int unsigned ae);
    return (width >= 1) && (depth >= 4) && ((depth & (depth - 1)) == 0) &&
           (af >= 1) && (af < depth) && (ae >= 1) && (ae < af);
  endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// FIFO storage: one synchronous write port, one asynchronous read port, no reset.
module sync_fifo_mem #(
  parameter int unsigned Width = 16,
  parameter int unsigned Depth = 8
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [$clog2(Depth)-1:0] waddr_i,
  input  logic [Width-1:0]         wdata_i,
  input  logic [$clog2(Depth)-1:0] raddr_i,
  output logic [Width-1:0]         rdata_o
);

  logic [Width-1:0] mem_q [Depth];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo_param.sv
// Parameterised synchronous FIFO with level flags and status pulses.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads; default is registered reads.
module sync_fifo_param
  import sync_fifo_pkg::*;
#(
  parameter int unsigned WIDTH    = DefWidth,
  parameter int unsigned DEPTH    = DefDepth,
  parameter int unsigned AF_LEVEL = DEPTH - 2,
  parameter int unsigned AE_LEVEL = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     rd_valid,
  output logic                     wr_ack,
  output logic                     overflow,
  output logic                     underflow,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned LvlW = PtrW + 1;

  if (!fifo_params_ok(WIDTH, DEPTH, AF_LEVEL, AE_LEVEL)) begin : g_param_check
    $error("sync_fifo_param: illegal WIDTH/DEPTH/AF_LEVEL/AE_LEVEL combination");
  end

  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LvlW-1:0]  level_q, level_d;
  logic             wr_ack_q, overflow_q, underflow_q;
  logic             rd_acc, wr_acc;
  logic [WIDTH-1:0] mem_rdata;

  assign empty        = (level_q == '0);
  assign full         = (level_q == LvlW'(DEPTH));
  assign almost_full  = (level_q >= LvlW'(AF_LEVEL));
  assign almost_empty = (level_q <= LvlW'(AE_LEVEL)) && !empty;
  assign level        = level_q;

  // A write into a full FIFO is allowed when a read frees a slot in the same cycle.
  assign rd_acc = rd_en && !empty;
  assign wr_acc = wr_en && (!full || rd_acc);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (wr_acc) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (rd_acc) rd_ptr_d = rd_ptr_q + PtrW'(1);
    if (wr_acc && !rd_acc) begin
      level_d = level_q + LvlW'(1);
    end else if (rd_acc && !wr_acc) begin
      level_d = level_q - LvlW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      wr_ack_q    <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      wr_ack_q    <= wr_acc;
      overflow_q  <= wr_en && !wr_acc;
      underflow_q <= rd_en && !rd_acc;
    end
  end

  assign wr_ack    = wr_ack_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

  sync_fifo_mem #(
    .Width (WIDTH),
    .Depth (DEPTH)
  ) u_mem (
    .clk_i   (clk),
    .we_i    (wr_acc),
    .waddr_i (wr_ptr_q),
    .wdata_i (wr_data),
    .raddr_i (rd_ptr_q),
    .rdata_o (mem_rdata)
  );

`ifdef SYNC_FIFO_FWFT_EN
  assign rd_data  = mem_rdata;
  assign rd_valid = !empty;
`else
  logic [WIDTH-1:0] rd_data_q;
  logic             rd_valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_acc;
      if (rd_acc) rd_data_q <= mem_rdata;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// Self-checking bench for sync_fifo_param: queue-based reference model plus directed vectors.
module tb_sync_fifo_param;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned AF    = 6;
  localparam int unsigned AE    = 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        wr_en = 1'b0;
  logic        rd_en = 1'b0;
  logic [15:0] wr_data = '0;
  logic [15:0] rd_data;
  logic        rd_valid, wr_ack, overflow, underflow;
  logic        full, empty, almost_full, almost_empty;
  logic [3:0]  level;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  sync_fifo_param #(
    .WIDTH    (WIDTH),
    .DEPTH    (DEPTH),
    .AF_LEVEL (AF),
    .AE_LEVEL (AE)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .rd_en        (rd_en),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .wr_ack       (wr_ack),
    .overflow     (overflow),
    .underflow    (underflow),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .level        (level)
  );

  function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Reference model: a queue of stored words and the pulses the last edge should produce.
  logic [15:0] mq[$];
  logic        m_wr_ack = 1'b0, m_ovf = 1'b0, m_unf = 1'b0, m_rv = 1'b0;
  logic [15:0] m_rd = '0;
  logic        ra, wa;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_wr_ack = 1'b0;
      m_ovf    = 1'b0;
      m_unf    = 1'b0;
      m_rv     = 1'b0;
      m_rd     = '0;
    end else begin
      ra = rd_en && (mq.size() != 0);
      wa = wr_en && ((mq.size() != DEPTH) || ra);
      m_wr_ack = wa;
      m_ovf    = wr_en && !wa;
      m_unf    = rd_en && !ra;
      m_rv     = ra;
      if (ra) m_rd = mq.pop_front();
      if (wa) mq.push_back(wr_data);
    end
  end

  always @(negedge clk) begin : cmp
    int sz;
    sz = mq.size();
    check("level", 32'(level), 32'(sz));
    check("empty", 32'(empty), 32'(sz == 0));
    check("full", 32'(full), 32'(sz == DEPTH));
    check("almost_full", 32'(almost_full), 32'(sz >= AF));
    check("almost_empty", 32'(almost_empty), 32'((sz <= AE) && (sz != 0)));
    check("wr_ack", 32'(wr_ack), 32'(m_wr_ack));
    check("overflow", 32'(overflow), 32'(m_ovf));
    check("underflow", 32'(underflow), 32'(m_unf));
`ifdef SYNC_FIFO_FWFT_EN
    check("rd_valid", 32'(rd_valid), 32'(sz != 0));
    if (sz != 0) check("rd_data", 32'(rd_data), 32'(mq[0]));
`else
    check("rd_valid", 32'(rd_valid), 32'(m_rv));
    check("rd_data", 32'(rd_data), 32'(m_rd));
`endif
  end

  task automatic cycle(input logic we, input logic [15:0] wd, input logic re);
    wr_en   = we;
    wr_data = wd;
    rd_en   = re;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  task automatic check_reset_outputs();
    check("rst level", 32'(level), 32'd0);
    check("rst empty", 32'(empty), 32'd1);
    check("rst full", 32'(full), 32'd0);
    check("rst almost_empty", 32'(almost_empty), 32'd0);
    check("rst rd_valid", 32'(rd_valid), 32'd0);
    check("rst wr_ack", 32'(wr_ack), 32'd0);
    check("rst overflow", 32'(overflow), 32'd0);
    check("rst underflow", 32'(underflow), 32'd0);
  endtask

  initial begin
    #2 rst_n = 1'b0;
    #1 check_reset_outputs();
`ifndef SYNC_FIFO_FWFT_EN
    check("rst rd_data", 32'(rd_data), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // Fill to full with 1..8.
    for (int i = 1; i <= 8; i++) begin
      cycle(1'b1, 16'(i), 1'b0);
      check("fill wr_ack", 32'(wr_ack), 32'd1);
      check("fill almost_full", 32'(almost_full), 32'(i >= 6));
    end
    check("fill full", 32'(full), 32'd1);
    check("fill level", 32'(level), 32'd8);

    // Write into full FIFO is rejected.
    cycle(1'b1, 16'hDEAD, 1'b0);
    check("ovf pulse", 32'(overflow), 32'd1);
    check("ovf level", 32'(level), 32'd8);
    check("ovf wr_ack", 32'(wr_ack), 32'd0);
    cycle(1'b0, 16'h0, 1'b0);
    check("ovf one cycle", 32'(overflow), 32'd0);

    // Simultaneous read+write on full FIFO.
`ifdef SYNC_FIFO_FWFT_EN
    check("full head", 32'(rd_data), 32'h0001);
`endif
    cycle(1'b1, 16'h0009, 1'b1);
    check("rw full level", 32'(level), 32'd8);
    check("rw full overflow", 32'(overflow), 32'd0);
    check("rw full wr_ack", 32'(wr_ack), 32'd1);
`ifndef SYNC_FIFO_FWFT_EN
    check("rw full rd_data", 32'(rd_data), 32'h0001);
    check("rw full rd_valid", 32'(rd_valid), 32'd1);
`endif
    for (int i = 0; i < 8; i++) begin
`ifdef SYNC_FIFO_FWFT_EN
      if (i == 7) check("ninth word", 32'(rd_data), 32'h0009);
`endif
      cycle(1'b0, 16'h0, 1'b1);
    end
`ifndef SYNC_FIFO_FWFT_EN
    check("ninth word", 32'(rd_data), 32'h0009);
`endif
    check("drained empty", 32'(empty), 32'd1);

    // Underflow, then read+write on empty.
    cycle(1'b0, 16'h0, 1'b1);
    check("unf pulse", 32'(underflow), 32'd1);
    check("unf rd_valid", 32'(rd_valid), 32'd0);
    check("unf level", 32'(level), 32'd0);
    cycle(1'b1, 16'h0055, 1'b1);
    check("rw empty underflow", 32'(underflow), 32'd1);
    check("rw empty level", 32'(level), 32'd1);
    check("rw empty almost_empty", 32'(almost_empty), 32'd1);
    cycle(1'b0, 16'h0, 1'b1);
    check("drain 0x55 level", 32'(level), 32'd0);

    // Interleaved 12 writes / 12 reads across pointer wrap.
    for (int i = 0; i < 12; i++) cycle(1'b1, 16'(16'h0100 + i), (i >= 2));
    cycle(1'b0, 16'h0, 1'b1);
    cycle(1'b0, 16'h0, 1'b1);
`ifndef SYNC_FIFO_FWFT_EN
    check("interleave last", 32'(rd_data), 32'h010B);
`endif
    check("interleave empty", 32'(empty), 32'd1);

    // Reset at level 5 with a write pending.
    for (int i = 0; i < 5; i++) cycle(1'b1, 16'(16'h0200 + i), 1'b0);
    check("pre-reset level", 32'(level), 32'd5);
    wr_en   = 1'b1;
    wr_data = 16'h02FF;
    #2 rst_n = 1'b0;
    #1 check_reset_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    wr_en = 1'b0;
    cycle(1'b1, 16'h0001, 1'b0);
    check("post-reset level", 32'(level), 32'd1);
`ifdef SYNC_FIFO_FWFT_EN
    check("post-reset fwft data", 32'(rd_data), 32'h0001);
    check("post-reset fwft valid", 32'(rd_valid), 32'd1);
`endif
    cycle(1'b0, 16'h0, 1'b1);
`ifndef SYNC_FIFO_FWFT_EN
    check("post-reset rd_data", 32'(rd_data), 32'h0001);
    check("post-reset rd_valid", 32'(rd_valid), 32'd1);
`endif
    check("post-reset empty", 32'(empty), 32'd1);

    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
